// File: rtl/episode_controller.sv
// Grid-world Q-learning agent: picks an epsilon-greedy action, computes the move and
// reward, hands one update transaction to the datapath and waits for its completion.
module episode_controller #(
   parameter int          STATES_WIDTH = 4,
   parameter int          DATA_WIDTH   = 16,
   parameter int          GRID_ROWS    = 4,
   parameter int          GRID_COLS    = 4,
   parameter int          START_STATE  = 0,
   parameter int          GOAL_STATE   = 15,
   parameter logic [7:0]  EPSILON      = 8'd26,
   parameter int          MAX_STEPS    = 64,
   parameter int          EPISODES     = 100,
   parameter int          REWARD_GOAL  = 100,
   parameter int          REWARD_STEP  = -1,
   parameter int          REWARD_WALL  = -10,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_start,
   input  logic [1:0]              i_at_max,
   input  logic                    i_q_valid,
   output logic                    o_valid,
   output logic [STATES_WIDTH-1:0] o_st,
   output logic [STATES_WIDTH-1:0] o_next_st,
   output logic [1:0]              o_at,
   output logic [DATA_WIDTH-1:0]   o_rt,
   output logic                    o_busy,
   output logic                    o_done,
   output logic [15:0]             o_episode
);

   // state    | meaning
   // S_IDLE   | waiting for i_start
   // S_SELECT | choose action, latch next state and reward
   // S_ISSUE  | o_valid strobe to the datapath
   // S_WAIT   | hold fields until i_q_valid, capture greedy hint
   // S_ADVANCE| move agent, count step, close episode if finished
   // S_DONE   | o_done strobe, back to idle
   typedef enum logic [2:0] {
      S_IDLE, S_SELECT, S_ISSUE, S_WAIT, S_ADVANCE, S_DONE
   } state_t;

   localparam logic [DATA_WIDTH-1:0]   RT_GOAL  = DATA_WIDTH'(REWARD_GOAL);
   localparam logic [DATA_WIDTH-1:0]   RT_STEP  = DATA_WIDTH'(REWARD_STEP);
   localparam logic [DATA_WIDTH-1:0]   RT_WALL  = DATA_WIDTH'(REWARD_WALL);
   localparam logic [STATES_WIDTH-1:0] ST_START = STATES_WIDTH'(START_STATE);
   localparam logic [STATES_WIDTH-1:0] ST_GOAL  = STATES_WIDTH'(GOAL_STATE);

   state_t                  r_state, w_state_nxt;
   logic [15:0]             r_lfsr;
   logic [15:0]             r_step;
   logic [15:0]             r_episode;
   logic [1:0]              r_hint;
   logic [1:0]              r_at;
   logic [STATES_WIDTH-1:0] r_st;
   logic [STATES_WIDTH-1:0] r_next_st;
   logic [DATA_WIDTH-1:0]   r_rt;

   logic [15:0]             w_lfsr_nxt;
   logic [1:0]              w_at;
   logic                    w_wall;
   int                      w_row, w_col, w_nrow, w_ncol;
   logic [STATES_WIDTH-1:0] w_next_st;
   logic [DATA_WIDTH-1:0]   w_rt;
   logic                    w_ep_end;
   logic                    w_last_ep;

   // Galois right-shift LFSR, taps 16,14,13,11
   assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

   always_comb begin
      w_at   = (r_lfsr[15:8] < EPSILON) ? r_lfsr[1:0] : r_hint;
      w_row  = int'(r_st) / GRID_COLS;
      w_col  = int'(r_st) % GRID_COLS;
      w_nrow = w_row;
      w_ncol = w_col;
      w_wall = 1'b0;
      case (w_at)
         2'd0: if (w_row == 0)             w_wall = 1'b1; else w_nrow = w_row - 1;
         2'd1: if (w_col == GRID_COLS - 1) w_wall = 1'b1; else w_ncol = w_col + 1;
         2'd2: if (w_row == GRID_ROWS - 1) w_wall = 1'b1; else w_nrow = w_row + 1;
         default: if (w_col == 0)          w_wall = 1'b1; else w_ncol = w_col - 1;
      endcase
      w_next_st = w_wall ? r_st : STATES_WIDTH'(w_nrow * GRID_COLS + w_ncol);
      // a wall bump outranks the goal reward, even when already sitting on the goal
      if (w_wall)                    w_rt = RT_WALL;
      else if (w_next_st == ST_GOAL) w_rt = RT_GOAL;
      else                           w_rt = RT_STEP;
   end

   assign w_ep_end  = (r_next_st == ST_GOAL) || (r_step == 16'(MAX_STEPS - 1));
   assign w_last_ep = (r_episode == 16'(EPISODES - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (i_start) w_state_nxt = S_SELECT;
         S_SELECT:  w_state_nxt = S_ISSUE;
         S_ISSUE:   w_state_nxt = S_WAIT;
         S_WAIT:    if (i_q_valid) w_state_nxt = S_ADVANCE;
         S_ADVANCE: w_state_nxt = (w_ep_end && w_last_ep) ? S_DONE : S_SELECT;
         S_DONE:    w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      o_valid = (r_state == S_ISSUE);
      o_done  = (r_state == S_DONE);
      o_busy  = (r_state != S_IDLE) && (r_state != S_DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_lfsr    <= LFSR_SEED;
         r_step    <= '0;
         r_episode <= '0;
         r_hint    <= '0;
         r_at      <= '0;
         r_st      <= ST_START;
         r_next_st <= '0;
         r_rt      <= '0;
      end else begin
         r_lfsr <= w_lfsr_nxt;
         case (r_state)
            S_IDLE: if (i_start) begin
               r_step    <= '0;
               r_episode <= '0;
               r_st      <= ST_START;
            end
            S_SELECT: begin
               r_at      <= w_at;
               r_next_st <= w_next_st;
               r_rt      <= w_rt;
            end
            S_WAIT: if (i_q_valid) r_hint <= i_at_max;
            S_ADVANCE: begin
               if (w_ep_end) begin
                  r_episode <= r_episode + 16'd1;
                  r_step    <= '0;
                  r_st      <= ST_START;
                  r_hint    <= '0;
               end else begin
                  r_step    <= r_step + 16'd1;
                  r_st      <= r_next_st;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_st      = r_st;
   assign o_next_st = r_next_st;
   assign o_at      = r_at;
   assign o_rt      = r_rt;
   assign o_episode = r_episode;

endmodule
